dmem_arbiter: RTL

Shares the single-port DMEM between the pipeline's MEM stage (core port) and an external debug/loader port (ext port). It sits between stage_MEM and the DMEM instance. The core has priority, but an anti-starvation counter and a bounded burst lock guarantee ext progress. The core is stalled whenever it loses the port.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DMEM arbiter: FSM encoding and default
// configuration values used by the arbiter and by the top level.
package dmem_arbiter_pkg;

    localparam int DMEM_ARB_REG_WIDTH    = 32;
    localparam int DMEM_ARB_STARVE_LIMIT = 4;   // legal range 1..15
    localparam int DMEM_ARB_MAX_LOCK     = 16;  // legal range 1..255

    typedef enum logic {
        DMEM_ARB_S_CORE = 1'b0,  // core owns the port; ext gets leftovers or a starve grant
        DMEM_ARB_S_EXT  = 1'b1   // ext holds the port for a locked burst
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DMEM between the MEM stage (core)
// and an external debug/loader port (ext). The core has priority; a
// saturating starve counter and a bounded locked burst guarantee ext
// progress. core_stall is asserted whenever the core loses the port.
//
// Optional build macro DMEM_ARB_STATS_EN adds the stat_stall_cnt and
// stat_ext_cnt counter ports.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int REG_WIDTH    = DMEM_ARB_REG_WIDTH,
    parameter int STARVE_LIMIT = DMEM_ARB_STARVE_LIMIT,
    parameter int MAX_LOCK     = DMEM_ARB_MAX_LOCK
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]          stat_stall_cnt,
    output logic [31:0]          stat_ext_cnt,
`endif
    input  logic                 core_req,
    input  logic                 core_wr_en,
    input  logic [REG_WIDTH-1:0] core_addr,
    input  logic [REG_WIDTH-1:0] core_wr_data,
    output logic [REG_WIDTH-1:0] core_rd_data,
    output logic                 core_stall,
    input  logic                 ext_req,
    input  logic                 ext_lock,
    input  logic                 ext_wr_en,
    input  logic [REG_WIDTH-1:0] ext_addr,
    input  logic [REG_WIDTH-1:0] ext_wr_data,
    output logic                 ext_gnt,
    output logic                 ext_rd_valid,
    output logic [REG_WIDTH-1:0] ext_rd_data,
    output logic                 dmem_wr_en,
    output logic [REG_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0] dmem_wr_data,
    input  logic [REG_WIDTH-1:0] dmem_data_out
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] LOCK_MAX   = 8'(MAX_LOCK);

    arb_state_e           state_q, state_d;
    logic [3:0]           starve_cnt_q, starve_cnt_d;
    logic [7:0]           lock_cnt_q, lock_cnt_d;
    logic                 ext_rd_valid_q, ext_rd_valid_d;
    logic [REG_WIDTH-1:0] ext_rd_data_q, ext_rd_data_d;
    logic                 core_gnt;

    // State register; reset drops any locked burst immediately.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= DMEM_ARB_S_CORE;
        else          state_q <= state_d;
    end

    // Next-state and burst-length tracking.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            DMEM_ARB_S_CORE: begin
                if (ext_gnt && ext_lock) begin
                    lock_cnt_d = 8'd1;
                    // A one-beat burst limit is already exhausted by this grant.
                    if (LOCK_MAX != 8'd1) state_d = DMEM_ARB_S_EXT;
                end
            end
            DMEM_ARB_S_EXT: begin
                if (!ext_req) begin
                    state_d = DMEM_ARB_S_CORE;
                end else begin
                    // lock_cnt counts grants of this burst including the current one.
                    lock_cnt_d = lock_cnt_q + 8'd1;
                    if (!ext_lock || lock_cnt_d == LOCK_MAX) state_d = DMEM_ARB_S_CORE;
                end
            end
            default: state_d = DMEM_ARB_S_CORE;
        endcase
    end

    // Grant, stall and DMEM port mux, combinational from state and counters.
    always_comb begin
        if (state_q == DMEM_ARB_S_EXT) ext_gnt = ext_req;
        else                           ext_gnt = ext_req && (!core_req || starve_cnt_q == STARVE_MAX);
        core_gnt   = core_req && !ext_gnt;
        core_stall = core_req && !core_gnt;
        if (ext_gnt) begin
            dmem_wr_en   = ext_wr_en;
            dmem_addr    = ext_addr;
            dmem_wr_data = ext_wr_data;
        end else begin
            dmem_wr_en   = core_wr_en && core_req;
            dmem_addr    = core_addr;
            dmem_wr_data = core_wr_data;
        end
    end

    // Starve counter saturates while ext waits; read capture for granted ext loads.
    always_comb begin
        if (ext_req && !ext_gnt)
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 4'd1;
        else
            starve_cnt_d = 4'd0;
        ext_rd_valid_d = ext_gnt && !ext_wr_en;
        ext_rd_data_d  = ext_rd_valid_d ? dmem_data_out : ext_rd_data_q;
    end

    // Counter and read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q   <= 4'd0;
            lock_cnt_q     <= 8'd0;
            ext_rd_valid_q <= 1'b0;
            ext_rd_data_q  <= '0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            lock_cnt_q     <= lock_cnt_d;
            ext_rd_valid_q <= ext_rd_valid_d;
            ext_rd_data_q  <= ext_rd_data_d;
        end
    end

    assign core_rd_data = dmem_data_out;
    assign ext_rd_valid = ext_rd_valid_q;
    assign ext_rd_data  = ext_rd_data_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_stall_cnt_q, stat_ext_cnt_q;

    // Free-running wrap-around event counters for stalls and ext grants.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_stall_cnt_q <= 32'd0;
            stat_ext_cnt_q   <= 32'd0;
        end else begin
            stat_stall_cnt_q <= stat_stall_cnt_q + 32'(core_stall);
            stat_ext_cnt_q   <= stat_ext_cnt_q + 32'(ext_gnt);
        end
    end

    assign stat_stall_cnt = stat_stall_cnt_q;
    assign stat_ext_cnt   = stat_ext_cnt_q;
`endif

endmodule
